// File: rtl/exp_golomb_engine.sv
`default_nettype none
// ============================================================================
// Module   : exp_golomb_engine
// Brief    : Reads one u(n), ue(v) or se(v) syntax element per request from a
//            peek-window bitstream reader and returns it on a result pulse.
// Revision : 1.0 - initial release
// ============================================================================
module exp_golomb_engine #(
    parameter int WIN    = 8,
    parameter int OUT_W  = 32,
    parameter int MAX_LZ = 31,
    parameter int LEN_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIN-1:0]          i_rbsp_in,
    input  logic [LEN_W-1:0]        i_num_zero_bits,
    output logic [LEN_W-1:0]        o_forward_len,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_mode,
    input  logic [LEN_W-1:0]        req_len,
    output logic                    res_valid,
    output logic signed [OUT_W-1:0] res_value,
    output logic                    res_error
);

    // Accumulator must hold a full-length u(n) as well as the 2^lz prefix.
    localparam int c_ACC_W = (MAX_LZ + 1 > OUT_W) ? MAX_LZ + 1 : OUT_W;
    localparam int c_LZ_W  = $clog2(MAX_LZ + WIN + 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_COUNT  = 3'd1;
    localparam logic [2:0] c_S_SUFFIX = 3'd2;
    localparam logic [2:0] c_S_WAIT   = 3'd3;
    localparam logic [2:0] c_S_RESULT = 3'd4;

    localparam logic [1:0] c_MODE_U  = 2'b00;
    localparam logic [1:0] c_MODE_UE = 2'b01;
    localparam logic [1:0] c_MODE_SE = 2'b10;

    logic [2:0]         r_state, w_next;
    logic [2:0]         r_ret, w_ret;
    logic [1:0]         r_mode, w_mode;
    logic [c_LZ_W-1:0]  r_lz, w_lz;
    logic [LEN_W-1:0]   r_left, w_left;
    logic [c_ACC_W-1:0] r_acc, w_acc;
    logic               r_err, w_err;
    logic [LEN_W-1:0]   w_fwd;

    logic [c_LZ_W-1:0]  w_lz_sum;
    logic               w_all_zero;
    logic [LEN_W-1:0]   w_n;
    logic [c_ACC_W-1:0] w_bits;
    logic [c_ACC_W-1:0] w_k;
    logic [c_ACC_W-1:0] w_half;
    logic [OUT_W-1:0]   w_val;

    assign w_lz_sum   = r_lz + c_LZ_W'(i_num_zero_bits);
    assign w_all_zero = (i_num_zero_bits == LEN_W'(WIN));
    assign w_n        = (r_left < LEN_W'(WIN)) ? r_left : LEN_W'(WIN);
    // Top w_n bits of the window, right-aligned.
    assign w_bits     = c_ACC_W'(i_rbsp_in >> (LEN_W'(WIN) - w_n));

    assign o_forward_len = w_fwd;

    always_comb begin
        w_next = r_state;
        w_ret  = r_ret;
        w_mode = r_mode;
        w_lz   = r_lz;
        w_left = r_left;
        w_acc  = r_acc;
        w_err  = r_err;
        w_fwd  = '0;
        case (r_state)
            c_S_IDLE: begin
                if (req_valid) begin
                    w_mode = req_mode;
                    w_lz   = '0;
                    w_acc  = '0;
                    w_left = '0;
                    w_err  = 1'b0;
                    case (req_mode)
                        c_MODE_U: begin
                            if (req_len == '0) begin
                                w_next = c_S_RESULT;
                            end else if (req_len > LEN_W'(OUT_W)) begin
                                w_err  = 1'b1;
                                w_next = c_S_RESULT;
                            end else begin
                                w_left = req_len;
                                w_next = c_S_SUFFIX;
                            end
                        end
                        c_MODE_UE, c_MODE_SE: w_next = c_S_COUNT;
                        default: begin
                            w_err  = 1'b1;
                            w_next = c_S_RESULT;
                        end
                    endcase
                end
            end
            c_S_COUNT: begin
                w_lz = w_lz_sum;
                if (w_all_zero) begin
                    w_fwd = LEN_W'(WIN);
                    if (w_lz_sum > c_LZ_W'(MAX_LZ)) begin
                        w_err  = 1'b1;
                        w_next = c_S_RESULT;
                    end else begin
                        w_next = c_S_WAIT;
                        w_ret  = c_S_COUNT;
                    end
                end else begin
                    // Consume the zeros plus the terminating one; acc seeds the 2^lz term.
                    w_fwd = i_num_zero_bits + LEN_W'(1);
                    w_acc = c_ACC_W'(1);
                    if (w_lz_sum > c_LZ_W'(MAX_LZ)) begin
                        w_err  = 1'b1;
                        w_next = c_S_RESULT;
                    end else if (w_lz_sum == '0) begin
                        w_next = c_S_WAIT;
                        w_ret  = c_S_RESULT;
                    end else begin
                        w_left = LEN_W'(w_lz_sum);
                        w_next = c_S_WAIT;
                        w_ret  = c_S_SUFFIX;
                    end
                end
            end
            c_S_SUFFIX: begin
                w_fwd  = w_n;
                w_acc  = (r_acc << w_n) | w_bits;
                w_left = r_left - w_n;
                w_next = c_S_WAIT;
                w_ret  = (r_left != w_n) ? c_S_SUFFIX : c_S_RESULT;
            end
            c_S_WAIT:   w_next = r_ret;
            c_S_RESULT: w_next = c_S_IDLE;
            default:    w_next = c_S_IDLE;
        endcase
    end

    // Result formed from the next-state view so it can be registered on entry to RESULT.
    always_comb begin
        w_k    = w_acc - c_ACC_W'(1);
        w_half = (w_k >> 1) + c_ACC_W'(1);
        case (w_mode)
            c_MODE_UE: w_val = OUT_W'(w_k);
            c_MODE_SE: w_val = w_k[0] ? OUT_W'(w_half) : -(OUT_W'(w_k >> 1));
            default:   w_val = OUT_W'(w_acc);
        endcase
        if (w_err) begin
            w_val = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_ret     <= c_S_IDLE;
            r_mode    <= '0;
            r_lz      <= '0;
            r_left    <= '0;
            r_acc     <= '0;
            r_err     <= 1'b0;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            res_value <= '0;
            res_error <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ret     <= w_ret;
            r_mode    <= w_mode;
            r_lz      <= w_lz;
            r_left    <= w_left;
            r_acc     <= w_acc;
            r_err     <= w_err;
            req_ready <= (w_next == c_S_IDLE);
            res_valid <= (w_next == c_S_RESULT);
            res_error <= (w_next == c_S_RESULT) && w_err;
            if (w_next == c_S_RESULT) begin
                res_value <= w_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_golomb_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_golomb_engine
// Brief    : Bitstream-reader model plus directed and random elements for
//            exp_golomb_engine, checked against values built from the codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp_golomb_engine;

    localparam int WIN      = 8;
    localparam int OUT_W    = 32;
    localparam int MAX_LZ   = 31;
    localparam int LEN_W    = 6;
    localparam int c_STREAM = 32768;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [WIN-1:0]          i_rbsp_in = '0;
    logic [LEN_W-1:0]        i_num_zero_bits = '0;
    logic [LEN_W-1:0]        o_forward_len;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic [1:0]              req_mode = '0;
    logic [LEN_W-1:0]        req_len = '0;
    logic                    res_valid;
    logic signed [OUT_W-1:0] res_value;
    logic                    res_error;

    exp_golomb_engine #(
        .WIN    (WIN),
        .OUT_W  (OUT_W),
        .MAX_LZ (MAX_LZ),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .i_rbsp_in       (i_rbsp_in),
        .i_num_zero_bits (i_num_zero_bits),
        .o_forward_len   (o_forward_len),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_mode        (req_mode),
        .req_len         (req_len),
        .res_valid       (res_valid),
        .res_value       (res_value),
        .res_error       (res_error)
    );

    always #5 clk = ~clk;

    bit               stream [c_STREAM];
    int               pos = 0;
    int               wp = 0;
    bit               in_wait = 1'b0;
    int               checks = 0;
    int               failures = 0;
    logic             q_rst = 1'b1;
    logic             q_valid = 1'b0;
    logic [1:0]       q_mode = '0;
    logic [LEN_W-1:0] q_len = '0;
    logic [LEN_W-1:0] s_fwd;
    logic             s_rv, s_rr, s_re;
    logic [OUT_W-1:0] s_val;
    int               fq[$];

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, consume at the rising edge.
    task automatic tick();
        int z;
        @(negedge clk);
        rst       = q_rst;
        req_valid = q_valid;
        req_mode  = q_mode;
        req_len   = q_len;
        if (in_wait) begin
            i_rbsp_in       = WIN'($urandom);
            i_num_zero_bits = LEN_W'($urandom_range(0, WIN));
        end else begin
            z = WIN;
            for (int i = 0; i < WIN; i++) begin
                i_rbsp_in[WIN-1-i] = stream[pos+i];
                if (stream[pos+i] && z == WIN) z = i;
            end
            i_num_zero_bits = LEN_W'(z);
        end
        #1;
        s_fwd = o_forward_len;
        s_rv  = res_valid;
        s_rr  = req_ready;
        s_re  = res_error;
        s_val = res_value;
        if (in_wait) chk_eq("wait_fwd_zero", longint'(s_fwd), 0);
        in_wait = (s_fwd != '0);
        if (s_fwd != '0) fq.push_back(int'(s_fwd));
        pos += int'(s_fwd);
    endtask

    task automatic put_bits(input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) begin
            stream[wp] = v[n-1-i];
            wp++;
        end
    endtask

    task automatic run_elem(input string tag, input logic [1:0] mode, input int len,
                            input bit hold, input longint exp_val, input bit exp_err,
                            input int exp_cons, input int exp_lat);
        int               start;
        int               lat;
        int               busy_ready;
        logic [OUT_W-1:0] val;
        bit               err;
        longint           mask;
        start      = pos;
        lat        = -1;
        busy_ready = 0;
        val        = '0;
        err        = 1'b0;
        mask       = (longint'(1) << OUT_W) - 1;
        fq.delete();
        q_valid = 1'b1;
        q_mode  = mode;
        q_len   = LEN_W'(len);
        tick();
        chk_eq({tag, ":accept_ready"}, longint'(s_rr), 1);
        if (!hold) q_valid = 1'b0;
        for (int t = 1; t <= 64 && lat < 0; t++) begin
            tick();
            if (s_rr) busy_ready++;
            if (s_rv) begin
                lat     = t;
                val     = s_val;
                err     = s_re;
                q_valid = 1'b0;
            end
        end
        chk_eq({tag, ":latency"}, longint'(lat), longint'(exp_lat));
        chk_eq({tag, ":value"}, longint'(val), exp_val & mask);
        chk_eq({tag, ":error"}, longint'(err), longint'(exp_err));
        chk_eq({tag, ":consumed"}, longint'(pos - start), longint'(exp_cons));
        chk_eq({tag, ":busy_ready"}, longint'(busy_ready), 0);
        tick();
        chk_eq({tag, ":idle_after"}, longint'({s_rv, s_rr, s_fwd}), longint'({1'b0, 1'b1, {LEN_W{1'b0}}}));
    endtask

    task automatic check_fq(input string tag, input int e[$]);
        chk_eq({tag, ":fwd_count"}, longint'(fq.size()), longint'(e.size()));
        for (int i = 0; i < e.size() && i < fq.size(); i++)
            chk_eq($sformatf("%s:fwd%0d", tag, i), longint'(fq[i]), longint'(e[i]));
    endtask

    task automatic rand_elem(input int idx);
        int         sel, L, n, cons, lat;
        longint     code, s, ev;
        bit         err, hold;
        logic [1:0] mode;
        hold = ($urandom_range(0, 3) == 0);
        sel  = $urandom_range(0, 19);
        wp   = pos;
        err  = 1'b0;
        ev   = 0;
        n    = $urandom_range(0, 63);
        if (sel < 12) begin
            mode = (sel < 6) ? 2'b01 : 2'b10;
            L = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_LZ + 1, MAX_LZ + 9)
                                            : $urandom_range(0, MAX_LZ);
            if (L > MAX_LZ) begin
                put_bits(L, 64'd0);
                put_bits(1, 64'd1);
                err  = 1'b1;
                cons = 0;
                while (cons <= MAX_LZ) cons += WIN;
                lat  = 2 * (cons / WIN);
            end else begin
                s = longint'({$urandom, $urandom}) & ((longint'(1) << L) - 1);
                put_bits(L, 64'd0);
                put_bits(1, 64'd1);
                put_bits(L, s);
                code = (longint'(1) << L) - 1 + s;
                if (mode == 2'b01) ev = code;
                else ev = (code % 2 == 1) ? (code + 1) / 2 : -(code / 2);
                cons = 2 * L + 1;
                lat  = 2 * (L / WIN + 1 + (L + WIN - 1) / WIN) + 1;
            end
        end else if (sel < 18) begin
            mode = 2'b00;
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(OUT_W + 1, (1 << LEN_W) - 1)
                                            : $urandom_range(0, OUT_W);
            if (n > OUT_W) begin
                err  = 1'b1;
                cons = 0;
                lat  = 1;
            end else begin
                s = longint'({$urandom, $urandom}) & ((longint'(1) << n) - 1);
                put_bits(n, s);
                ev   = s;
                cons = n;
                lat  = (n == 0) ? 1 : 2 * ((n + WIN - 1) / WIN) + 1;
            end
        end else begin
            mode = 2'b11;
            err  = 1'b1;
            cons = 0;
            lat  = 1;
        end
        run_elem($sformatf("rnd%0d", idx), mode, n, hold, ev, err, cons, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int     e[$];
        longint v;
        int     start;
        for (int i = 0; i < c_STREAM; i++) stream[i] = 1'($urandom);

        // Reset state
        q_rst = 1'b1;
        tick();
        tick();
        chk_eq("reset_ready", longint'(s_rr), 1);
        chk_eq("reset_res_valid", longint'(s_rv), 0);
        chk_eq("reset_res_error", longint'(s_re), 0);
        chk_eq("reset_res_value", longint'(s_val), 0);
        chk_eq("reset_fwd", longint'(s_fwd), 0);
        q_rst = 1'b0;
        tick();

        // ue, lz=0
        wp = pos; put_bits(1, 64'd1);
        run_elem("ue_one", 2'b01, 0, 1'b0, 0, 1'b0, 1, 3);
        e = {1}; check_fq("ue_one", e);

        // 00111 as ue and se, 00110 as se
        wp = pos; put_bits(5, 64'b00111);
        run_elem("ue_6", 2'b01, 0, 1'b0, 6, 1'b0, 5, 5);
        e = {3, 2}; check_fq("ue_6", e);
        wp = pos; put_bits(5, 64'b00111);
        run_elem("se_m3", 2'b10, 0, 1'b0, -3, 1'b0, 5, 5);
        wp = pos; put_bits(5, 64'b00110);
        run_elem("se_p3", 2'b10, 0, 1'b0, 3, 1'b0, 5, 5);

        // Long ue crossing windows
        wp = pos; put_bits(10, 64'd0); put_bits(1, 64'd1); put_bits(10, 64'b0000000101);
        run_elem("ue_long", 2'b01, 0, 1'b0, 1028, 1'b0, 21, 9);
        e = {8, 3, 8, 2}; check_fq("ue_long", e);

        // u(n)
        wp = pos; put_bits(3, 64'b101);
        run_elem("u3", 2'b00, 3, 1'b0, 5, 1'b0, 3, 3);
        v = longint'($urandom_range(0, 4095));
        wp = pos; put_bits(12, v);
        run_elem("u12", 2'b00, 12, 1'b0, v, 1'b0, 12, 5);
        e = {8, 4}; check_fq("u12", e);
        run_elem("u0", 2'b00, 0, 1'b0, 0, 1'b0, 0, 1);
        e = {}; check_fq("u0", e);

        // Errors
        wp = pos; put_bits(32, 64'd0); put_bits(1, 64'd1);
        run_elem("ue_toolong", 2'b01, 0, 1'b0, 0, 1'b1, 32, 8);
        e = {8, 8, 8, 8}; check_fq("ue_toolong", e);
        run_elem("mode11", 2'b11, 0, 1'b0, 0, 1'b1, 0, 1);
        run_elem("u33", 2'b00, 33, 1'b0, 0, 1'b1, 0, 1);

        // req_valid held through the whole element
        wp = pos; put_bits(5, 64'b00111);
        run_elem("hold_se", 2'b10, 0, 1'b1, -3, 1'b0, 5, 5);

        // Reset in the first SUFFIX cycle of u(20)
        wp = pos; put_bits(20, longint'($urandom));
        start   = pos;
        q_valid = 1'b1; q_mode = 2'b00; q_len = LEN_W'(20);
        tick();
        q_valid = 1'b0; q_rst = 1'b1;
        tick();
        chk_eq("rst_sfx_fwd", longint'(s_fwd), 8);
        q_rst = 1'b0;
        tick();
        chk_eq("rst_after_fwd", longint'(s_fwd), 0);
        chk_eq("rst_after_valid", longint'(s_rv), 0);
        chk_eq("rst_after_ready", longint'(s_rr), 1);
        chk_eq("rst_consumed", longint'(pos - start), 8);

        for (int i = 0; i < 250; i++) rand_elem(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
